// File: rtl/fetch_queue_pkg.sv
// Shared constants and helpers for the IF->ID fetch queue.
// Holds the NOP encoding and the per-cycle queue operation decode.
package fetch_queue_pkg;

    localparam int unsigned DATA_W_DEFAULT = 32;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

    typedef enum logic [1:0] {
        OpNone  = 2'b00,
        OpWrite = 2'b01,
        OpRead  = 2'b10,
        OpBoth  = 2'b11
    } fq_op_e;

    function automatic fq_op_e decode_op(input logic write, input logic read);
        return fq_op_e'({read, write});
    endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: one synchronous write port, one
// asynchronous read port. Contents are deliberately not reset.
module fetch_queue_mem #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// In-order {instruction, PC+4} buffer between IF and ID with back-pressure
// toward IF and a flush that empties the queue on a taken branch or jump.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_if_valid,
    input  logic [DATA_W-1:0]        i_if_instruction,
    input  logic [DATA_W-1:0]        i_if_pci,
    output logic                     o_if_ready,
    input  logic                     i_flush,
    input  logic                     i_id_stall,
    output logic                     o_id_valid,
    output logic [DATA_W-1:0]        o_id_instruction,
    output logic [DATA_W-1:0]        o_id_pci,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic                w_full;
    logic                w_empty;
    logic                w_if_ready;
    logic                w_write;
    logic                w_read;
    fq_op_e              w_op;
    logic [CNT_W-1:0]    w_count_next;
    logic [2*DATA_W-1:0] w_wdata;
    logic [2*DATA_W-1:0] w_rdata;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // Ready depends on state only; a read while full does not open a slot this cycle.
    assign w_if_ready = ~i_rst & ~w_full;
    assign w_write    = i_if_valid & w_if_ready & ~i_flush;
    assign w_read     = ~w_empty & ~i_id_stall & ~i_flush;
    assign w_op       = decode_op(w_write, w_read);

    always_comb begin
        w_count_next = r_count;
        unique case (w_op)
            OpWrite: w_count_next = r_count + 1'b1;
            OpRead:  w_count_next = r_count - 1'b1;
            OpBoth:  w_count_next = r_count;
            OpNone:  w_count_next = r_count;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_read) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
        end
    end

    assign w_wdata = {i_if_instruction, i_if_pci};

    fetch_queue_mem #(
        .DEPTH  (DEPTH),
        .WIDTH  (2 * DATA_W),
        .ADDR_W (PTR_W)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_write),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    // Storage is never reset, so outputs are forced to constants when empty.
    assign o_if_ready       = w_if_ready;
    assign o_id_valid       = ~w_empty;
    assign o_id_instruction = w_empty ? DATA_W'(NOP_INSTR) : w_rdata[2*DATA_W-1:DATA_W];
    assign o_id_pci         = w_empty ? '0 : w_rdata[DATA_W-1:0];
    assign o_count          = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios then random traffic, all checked
// against a queue-based reference model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_valid;
    logic [DATA_W-1:0] if_instr;
    logic [DATA_W-1:0] if_pci;
    logic              if_ready;
    logic              flush;
    logic              id_stall;
    logic              id_valid;
    logic [DATA_W-1:0] id_instr;
    logic [DATA_W-1:0] id_pci;
    logic [2:0]        count;

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0] q[$];

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_if_valid       (if_valid),
        .i_if_instruction (if_instr),
        .i_if_pci         (if_pci),
        .o_if_ready       (if_ready),
        .i_flush          (flush),
        .i_id_stall       (id_stall),
        .o_id_valid       (id_valid),
        .o_id_instruction (id_instr),
        .o_id_pci         (id_pci),
        .o_count          (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic        exp_ready;
        logic [31:0] exp_instr;
        logic [31:0] exp_pci;
        exp_ready = !rst && (q.size() != DEPTH);
        exp_instr = (q.size() != 0) ? q[0][63:32] : NOP_INSTR;
        exp_pci   = (q.size() != 0) ? q[0][31:0] : 32'h0;
        chk({tag, ".if_ready"}, {31'b0, if_ready}, {31'b0, exp_ready});
        chk({tag, ".id_valid"}, {31'b0, id_valid}, {31'b0, q.size() != 0});
        chk({tag, ".id_instr"}, id_instr, exp_instr);
        chk({tag, ".id_pci"}, id_pci, exp_pci);
        chk({tag, ".count"}, {29'b0, count}, 32'(q.size()));
    endtask

    // Model evaluates this cycle's inputs, then one clock edge passes.
    task automatic step(input string tag);
        bit          ready;
        bit          wr;
        bit          rd;
        logic [63:0] ent;
        ready = !rst && (q.size() != DEPTH);
        wr    = if_valid && ready && !flush;
        rd    = (q.size() != 0) && !id_stall && !flush;
        ent   = {if_instr, if_pci};
        @(posedge clk);
        #1;
        if (rst || flush) begin
            q.delete();
        end else begin
            if (rd) void'(q.pop_front());
            if (wr) q.push_back(ent);
        end
        check_all(tag);
    endtask

    initial begin
        rst      = 1'b1;
        if_valid = 1'b0;
        if_instr = '0;
        if_pci   = '0;
        flush    = 1'b0;
        id_stall = 1'b0;
        #2;
        // 1: reset then idle
        check_all("t1_rst");
        step("t1_rst_edge");
        rst = 1'b0;
        #1;
        chk("t1_ready_after", {31'b0, if_ready}, 32'd1);
        step("t1_idle");

        // 2: fill with stall, fifth write ignored
        id_stall = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            if_valid = 1'b1;
            if_instr = 32'h2008_0000 + 32'(i);
            if_pci   = 32'(4 * i);
            step("t2_fill");
        end
        chk("t2_count", {29'b0, count}, 32'd4);
        chk("t2_ready", {31'b0, if_ready}, 32'd0);
        if_valid = 1'b0;

        // 3: drain in order
        id_stall = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk("t3_head", id_instr, 32'h2008_0000 + 32'(i));
            chk("t3_pci", id_pci, 32'(4 * i));
            step("t3_drain");
        end
        chk("t3_empty_nop", id_instr, 32'h0);

        // 4: full with simultaneous fetch and read
        id_stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            if_valid = 1'b1;
            if_instr = 32'h1000_0000 + 32'(i);
            if_pci   = 32'h100 + 32'(4 * i);
            step("t4_fill");
        end
        id_stall = 1'b0;
        if_instr = 32'h1000_0005;
        step("t4_full_rw");
        chk("t4_count", {29'b0, count}, 32'd3);

        // 5: flush with write and read at count 3
        flush = 1'b1;
        if_instr = 32'h1000_0006;
        step("t5_flush");
        chk("t5_count", {29'b0, count}, 32'd0);
        flush = 1'b0;
        if_instr = 32'hCAFE_0001;
        if_pci   = 32'h0000_0404;
        step("t5_after");
        chk("t5_head", id_instr, 32'hCAFE_0001);
        if_valid = 1'b0;
        step("t5_drain");

        // 6: wrap at count 1, then async reset mid-stream
        if_valid = 1'b1;
        id_stall = 1'b1;
        if_instr = 32'hA000_0000;
        if_pci   = 32'h0;
        step("t6_prime");
        id_stall = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if_instr = 32'hA000_0000 + 32'(i);
            if_pci   = 32'(8 * i);
            step("t6_wrap");
            chk("t6_count", {29'b0, count}, 32'd1);
        end
        rst = 1'b1;
        #1;
        chk("t6_async_valid", {31'b0, id_valid}, 32'd0);
        chk("t6_async_ready", {31'b0, if_ready}, 32'd0);
        q.delete();
        check_all("t6_async");
        step("t6_rst_edge");
        rst = 1'b0;
        if_valid = 1'b0;
        step("t6_release");

        // random traffic
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 79) == 0);
            if_valid = ($urandom_range(0, 3) != 0);
            id_stall = ($urandom_range(0, 2) == 0);
            flush    = ($urandom_range(0, 19) == 0);
            if_instr = $urandom;
            if_pci   = $urandom;
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
